// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity framer and its helpers.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY
   } frame_state_t;

   localparam bit PAR_EVEN = 1'b0;
   localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_framer_if.sv
// Word-load and bit-serial handshake bundle for serial_parity_framer.
interface serial_parity_framer_if #(
   parameter int unsigned WIDTH = 8
);

   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_ready;
   logic             ser_first;
   logic             ser_last;
   logic             busy;

   // master: producer/consumer side; slave: the framer itself
   modport master (
      output load_valid, load_data, ser_ready,
      input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy
   );

   modport slave (
      input  load_valid, load_data, ser_ready,
      output load_ready, ser_out, ser_valid, ser_first, ser_last, busy
   );

endinterface

// File: rtl/parity_accum.sv
// One-bit toggle accumulator: z flips on every en && x, clear wins over en.
module parity_accum (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   input  logic x,
   output logic z
);

   logic z_q, z_d;

   always_comb begin
      z_d = z_q;
      if (clear) begin
         z_d = 1'b0;
      end else if (en && x) begin
         z_d = ~z_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         z_q <= 1'b0;
      end else begin
         z_q <= z_d;
      end
   end

   assign z = z_q;

endmodule

// File: rtl/serial_parity_framer.sv
// Shifts a parallel word out LSB-first over a valid/ready stream and appends a parity bit.
module serial_parity_framer
   import parity_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter bit          ODD_PARITY = PAR_EVEN
) (
   input  logic                  clock,
   input  logic                  reset_n,
   serial_parity_framer_if.slave bus
);

   localparam int unsigned CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   frame_state_t     state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    count_q, count_d;
   logic             accept;
   logic             data_xfer;
   logic             acc;

   assign accept    = (state_q == IDLE) && bus.load_valid;
   assign data_xfer = (state_q == DATA) && bus.ser_ready;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               shift_d = bus.load_data;
               count_d = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bus.ser_ready) begin
               shift_d = shift_q >> 1;
               count_d = count_q + CW'(1);
               if (count_q == LAST_BIT) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (bus.ser_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         count_q <= count_d;
      end
   end

   // Sees each data bit exactly once, on its transfer cycle.
   parity_accum u_accum (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (accept),
      .en      (data_xfer),
      .x       (shift_q[0]),
      .z       (acc)
   );

   // Outputs decode registered state only; no path from ser_ready or load_valid.
   always_comb begin
      bus.ser_out = 1'b0;
      unique case (state_q)
         DATA:    bus.ser_out = shift_q[0];
         PARITY:  bus.ser_out = acc ^ ODD_PARITY;
         default: bus.ser_out = 1'b0;
      endcase
   end

   assign bus.load_ready = (state_q == IDLE);
   assign bus.ser_valid  = (state_q != IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.ser_first  = (state_q == DATA) && (count_q == '0);
   assign bus.ser_last   = (state_q == PARITY);

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench: 8-bit framers in even and odd mode side by side, plus 1-bit framers.
module tb_serial_parity_framer;
   import parity_pkg::*;

   logic       clock      = 1'b0;
   logic       reset_n    = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_data  = '0;
   logic       ser_ready  = 1'b1;
   logic       lv1        = 1'b0;
   logic       ld1        = 1'b0;

   int unsigned total = 0;
   int unsigned bad   = 0;

   serial_parity_framer_if #(.WIDTH(8)) bus_e ();
   serial_parity_framer_if #(.WIDTH(8)) bus_o ();
   serial_parity_framer_if #(.WIDTH(1)) bus_1e ();
   serial_parity_framer_if #(.WIDTH(1)) bus_1o ();

   assign bus_e.load_valid  = load_valid;
   assign bus_e.load_data   = load_data;
   assign bus_e.ser_ready   = ser_ready;
   assign bus_o.load_valid  = load_valid;
   assign bus_o.load_data   = load_data;
   assign bus_o.ser_ready   = ser_ready;
   assign bus_1e.load_valid = lv1;
   assign bus_1e.load_data  = ld1;
   assign bus_1e.ser_ready  = ser_ready;
   assign bus_1o.load_valid = lv1;
   assign bus_1o.load_data  = ld1;
   assign bus_1o.ser_ready  = ser_ready;

   serial_parity_framer #(.WIDTH(8), .ODD_PARITY(PAR_EVEN)) dut_e (
      .clock (clock), .reset_n (reset_n), .bus (bus_e)
   );
   serial_parity_framer #(.WIDTH(8), .ODD_PARITY(PAR_ODD)) dut_o (
      .clock (clock), .reset_n (reset_n), .bus (bus_o)
   );
   serial_parity_framer #(.WIDTH(1), .ODD_PARITY(PAR_EVEN)) dut_1e (
      .clock (clock), .reset_n (reset_n), .bus (bus_1e)
   );
   serial_parity_framer #(.WIDTH(1), .ODD_PARITY(PAR_ODD)) dut_1o (
      .clock (clock), .reset_n (reset_n), .bus (bus_1o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle8(input string tag);
      check({tag, "_e_ready"}, bus_e.load_ready, 1);
      check({tag, "_o_ready"}, bus_o.load_ready, 1);
      check({tag, "_e_valid"}, bus_e.ser_valid, 0);
      check({tag, "_o_valid"}, bus_o.ser_valid, 0);
      check({tag, "_e_busy"},  bus_e.busy, 0);
      check({tag, "_e_out"},   bus_e.ser_out, 0);
      check({tag, "_e_first"}, bus_e.ser_first, 0);
      check({tag, "_e_last"},  bus_e.ser_last, 0);
   endtask

   task automatic check_sym(input string tag, input logic out_e, input logic out_o,
                            input logic first, input logic last);
      check({tag, "_e_valid"}, bus_e.ser_valid, 1);
      check({tag, "_o_valid"}, bus_o.ser_valid, 1);
      check({tag, "_e_out"},   bus_e.ser_out, out_e);
      check({tag, "_o_out"},   bus_o.ser_out, out_o);
      check({tag, "_e_first"}, bus_e.ser_first, first);
      check({tag, "_e_last"},  bus_e.ser_last, last);
      check({tag, "_o_last"},  bus_o.ser_last, last);
      check({tag, "_e_busy"},  bus_e.busy, 1);
      check({tag, "_e_ready"}, bus_e.load_ready, 0);
   endtask

   task automatic start8(input logic [7:0] word);
      load_valid = 1'b1;
      load_data  = word;
      tick();
      load_valid = 1'b0;
      load_data  = ~word;
   endtask

   // stall_bit/poke_bit < 0 disables; par_stall counts held cycles on the parity symbol.
   task automatic run8(input string name, input logic [7:0] word, input logic par_e,
                       input logic par_o, input int stall_bit, input int stall_len,
                       input int par_stall, input int poke_bit);
      check_idle8({name, "_pre"});
      start8(word);
      for (int k = 0; k < 8; k++) begin
         check_sym($sformatf("%s_b%0d", name, k), word[k], word[k], k == 0, 1'b0);
         if (k == stall_bit) begin
            ser_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               check_sym($sformatf("%s_hold%0d", name, s), word[k], word[k], k == 0, 1'b0);
               check($sformatf("%s_hold%0d_cnt", name, s), 32'(dut_e.count_q), k);
            end
            ser_ready = 1'b1;
         end
         if (k == poke_bit) begin
            load_valid = 1'b1;
            load_data  = 8'h00;
         end
         tick();
         load_valid = 1'b0;
      end
      check_sym({name, "_par"}, par_e, par_o, 1'b0, 1'b1);
      if (par_stall > 0) begin
         ser_ready = 1'b0;
         for (int s = 0; s < par_stall; s++) begin
            tick();
            check_sym($sformatf("%s_parhold%0d", name, s), par_e, par_o, 1'b0, 1'b1);
         end
         ser_ready = 1'b1;
      end
      tick();
      check_idle8({name, "_post"});
   endtask

   logic w1_word [2] = '{1'b1, 1'b0};
   logic w1_pe   [2] = '{1'b1, 1'b0};
   logic w1_po   [2] = '{1'b0, 1'b1};

   initial begin
      // Reset held with load_valid high: reset must win.
      load_valid = 1'b1;
      load_data  = 8'hFF;
      lv1        = 1'b1;
      repeat (2) tick();
      check_idle8("rst");
      check("rst_cnt", 32'(dut_e.count_q), 0);
      check("rst_shift", 32'(dut_e.shift_q), 0);
      check("rst_1e_ready", bus_1e.load_ready, 1);
      check("rst_1e_valid", bus_1e.ser_valid, 0);
      load_valid = 1'b0;
      lv1        = 1'b0;
      reset_n    = 1'b1;
      tick();
      check_idle8("rel");

      run8("a5", 8'hA5, 1'b0, 1'b1, -1, 0, 0, -1);
      run8("07", 8'h07, 1'b1, 1'b0, -1, 0, 0, -1);
      run8("ff", 8'hFF, 1'b0, 1'b1, 4, 3, 2, -1);
      run8("3c", 8'h3C, 1'b0, 1'b1, -1, 0, 0, 2);
      run8("00", 8'h00, 1'b0, 1'b1, -1, 0, 0, -1);

      // Abort mid-frame at data bit 3 after three 1s have gone into the accumulator.
      start8(8'h07);
      for (int k = 0; k < 3; k++) begin
         check_sym($sformatf("ab_b%0d", k), 1'b1, 1'b1, k == 0, 1'b0);
         tick();
      end
      check_sym("ab_b3", 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check_idle8("ab_after");
      run8("01", 8'h01, 1'b1, 1'b0, -1, 0, 0, -1);
      run8("80", 8'h80, 1'b1, 1'b0, -1, 0, 0, -1);

      for (int i = 0; i < 2; i++) begin
         check($sformatf("w1_%0d_pre_ready", i), bus_1e.load_ready, 1);
         lv1 = 1'b1;
         ld1 = w1_word[i];
         tick();
         lv1 = 1'b0;
         ld1 = ~w1_word[i];
         check($sformatf("w1_%0d_d_valid", i), bus_1e.ser_valid, 1);
         check($sformatf("w1_%0d_d_out", i), bus_1e.ser_out, w1_word[i]);
         check($sformatf("w1_%0d_d_first", i), bus_1e.ser_first, 1);
         check($sformatf("w1_%0d_d_last", i), bus_1e.ser_last, 0);
         check($sformatf("w1_%0d_d_o_first", i), bus_1o.ser_first, 1);
         tick();
         check($sformatf("w1_%0d_p_last", i), bus_1e.ser_last, 1);
         check($sformatf("w1_%0d_p_first", i), bus_1e.ser_first, 0);
         check($sformatf("w1_%0d_p_e_out", i), bus_1e.ser_out, w1_pe[i]);
         check($sformatf("w1_%0d_p_o_out", i), bus_1o.ser_out, w1_po[i]);
         tick();
         check($sformatf("w1_%0d_idle_ready", i), bus_1e.load_ready, 1);
         check($sformatf("w1_%0d_idle_valid", i), bus_1o.ser_valid, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
